bpu_update_ctrl: RTL and testbench
==================================

# bpu_update_ctrl

Commit-side update engine for the micro branch predictor. It accepts resolved-branch records from the backend and queues them. For each record it computes the new 2-bit saturating counter and the uPHT write index from the GHR snapshot. It then drives the uBTB and uPHT write ports, which are the `i_ubtb_update` / `i_upht_update` side of the fetch-stage predictor, under a per-update handshake.

## Interface
- `DEPTH`, 4: resolved-branch queue entries; power of two, ≥2.
- `GHR_W`, 10: GHR snapshot width.
- `PHT_IDX_W`, `$clog2(`SAT_TABLE_SIZE)`: uPHT index width, 9 at 512 entries.
- `i_clk` in 1: clock; the block uses one clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_br_valid` in 1: resolved-branch record valid.
- `o_br_ready` out 1: queue can accept a record.
- `i_br_pc` in `MXLEN`: branch PC.
- `i_br_target` in `MXLEN`: resolved target.
- `i_br_taken` in 1: resolved direction.
- `i_br_mispred` in 1: direction or target mispredicted.
- `i_br_ghr` in `GHR_W`: GHR snapshot taken at predict time.
- `i_br_cnt` in 2: uPHT counter value read at predict time.
- `o_upht_update` out 1: uPHT write request.
- `o_upht_wr_addr` out `PHT_IDX_W`: uPHT write index.
- `o_upht_wr_cnt` out 2: new counter value.
- `o_ubtb_update` out 1: uBTB write request.
- `o_ubtb_jumpsrc` out `MXLEN`: uBTB write source PC.
- `o_ubtb_jumpdst` out `MXLEN`: uBTB write target.
- `i_upd_ready` in 1: predictor arrays accept this cycle's writes; fetch reads have priority.
- `o_ghr_repair_vld` out 1: present only with `BPU_GHR_REPAIR_EN`.
- `o_ghr_repair` out `GHR_W`: present only with `BPU_GHR_REPAIR_EN`.

## Operation
- Record accepted when `i_br_valid && o_br_ready`. `o_br_ready = !full`; there is no pass-through when the queue is full, even if it pops that cycle.
- FIFO uses wrap-around pointers with an extra MSB to distinguish full from empty.
- Index and counter are computed from the queue head:
  - Index = `pc[PHT_IDX_W+2:3] ^ ghr[PHT_IDX_W-1:0]`.
  - Taken: cnt==3 ? 3 : cnt+1.
  - Not taken: cnt==0 ? 0 : cnt-1.
- `o_upht_update` = head valid and new cnt ≠ old cnt. A saturated, unchanged counter is not written.
- `o_ubtb_update` = head valid and (taken or mispred).
  - If not taken and mispredicted, the write is an invalidation with `o_ubtb_jumpdst` = pc+4.
- A head with neither write pending pops immediately in S_ISSUE without waiting for `i_upd_ready`.
- FSM:
  - S_IDLE: queue empty; all write outputs 0. Moves to S_ISSUE when the queue becomes non-empty.
  - S_ISSUE: head writes asserted and held stable until `i_upd_ready`. On handshake, pop; stay in S_ISSUE if entries remain, else go to S_IDLE.
- Simultaneous push and pop when not full: both take effect; occupancy is unchanged.
- Reset mid-operation: queue cleared, pending writes dropped, state S_IDLE.

## Timing
- Reset values:
  - All `o_upht_*`, `o_ubtb_*` and `o_ghr_repair*` are 0.
  - `o_br_ready` is 1, since the queue is empty.
- Latency: a record pushed in cycle N drives the write ports from cycle N+1 at the earliest, when the queue was empty.
- Throughput: one update per cycle while `i_upd_ready` is held high.
- Write outputs come from registered head state plus combinational next-cnt; they have no dependency on `i_br_*` in the same cycle.

## Configuration
- `BPU_GHR_REPAIR_EN` defined:
  - On acceptance of a record with `i_br_mispred`=1, `o_ghr_repair_vld` pulses for one cycle in N+1.
  - `o_ghr_repair = {i_br_ghr[GHR_W-2:0], i_br_taken}`, registered.
  - This path is independent of queue occupancy.
- Not defined: the repair ports and the repair register are absent.

## Structure
- Shared package `bpu_pkg` holds:
  - `bpu_upd_t` struct (pc, target, taken, mispred, ghr, cnt).
  - `sat_cnt_t` (2-bit).
  - Function `sat_cnt_next(cnt, taken)`.
  - Constants `GHR_W` and `PHT_IDX_W`.
- One sub-module: `bpu_upd_fifo`, a parameterised `DEPTH` × `bpu_upd_t` FIFO with push/pop/full/empty.
- The FSM and update logic sit at top level.

## Test plan
- Reset, then one record: pc=0x1008, ghr=0x005, cnt=1, taken=1.
  - Cycle+1: `o_upht_update`=1, addr=0x001^0x005=0x004, cnt=2.
  - `o_ubtb_update`=1, src=0x1008, dst=target.
  - `i_upd_ready`=1 → S_IDLE next cycle.
- Saturation: cnt=3, taken=1, mispred=0.
  - `o_upht_update`=0, `o_ubtb_update`=1.
  - Same test with cnt=0, taken=0, mispred=0: no writes, entry pops in one cycle.
- Back-pressure: push 5 records with `i_upd_ready`=0.
  - `o_br_ready` falls after 4; the 5th is held.
  - Outputs stay stable on the head.
  - Release `i_upd_ready`: 4 updates issue in order on consecutive cycles.
- Simultaneous push/pop at occupancy 2: occupancy remains 2 and ordering is preserved.
- Reset asserted mid S_ISSUE with 3 entries: outputs 0 immediately (async); after release the queue is empty and `o_br_ready`=1.
- With `BPU_GHR_REPAIR_EN`: mispred record with ghr=0x2AA, taken=1 → `o_ghr_repair`=0x155 with a one-cycle `o_ghr_repair_vld`; a non-mispred record gives no pulse.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types, constants and counter helper for the micro branch predictor update path.
// Latency: none (definitions only).
// Backpressure: none here; the modules that import this package own their handshakes.
package bpu_pkg;

    localparam int MXLEN          = 32;
    localparam int SAT_TABLE_SIZE = 512;
    localparam int GHR_W          = 10;
    localparam int PHT_IDX_W      = $clog2(SAT_TABLE_SIZE);

    typedef logic [1:0] sat_cnt_t;

    // One resolved branch as it travels through the update queue.
    typedef struct packed {
        logic [MXLEN-1:0] pc;
        logic [MXLEN-1:0] target;
        logic             taken;
        logic             mispred;
        logic [GHR_W-1:0] ghr;
        sat_cnt_t         cnt;
    } bpu_upd_t;

    // 2-bit saturating counter step towards the resolved direction.
    function automatic sat_cnt_t sat_cnt_next(input sat_cnt_t cnt, input logic taken);
        sat_cnt_t nxt;
        if (taken) begin
            nxt = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
        end else begin
            nxt = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// DEPTH-entry queue of resolved-branch records with push/pop/full/empty and occupancy.
// Latency: a pushed entry is visible at the head on the next cycle (no fall-through).
// Backpressure: push is ignored while full, pop is ignored while empty.
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   push,
    input  bpu_upd_t               push_dat,
    input  logic                   pop,
    output bpu_upd_t               head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    bpu_upd_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB tells a full queue (MSBs differ) from an empty one (pointers equal).
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Wrap-around pointers; reset empties the queue.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset: it is only read behind a valid head.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Commit-side uBTB/uPHT update engine; optional GHR repair output under BPU_GHR_REPAIR_EN.
// Latency: record accepted in cycle N drives the write ports from N+1 when the queue was empty.
// Backpressure: o_br_ready = !full (no pass-through); head writes held stable until i_upd_ready.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_br_valid,
    output logic                 o_br_ready,
    input  logic [MXLEN-1:0]     i_br_pc,
    input  logic [MXLEN-1:0]     i_br_target,
    input  logic                 i_br_taken,
    input  logic                 i_br_mispred,
    input  logic [GHR_W-1:0]     i_br_ghr,
    input  logic [1:0]           i_br_cnt,
    output logic                 o_upht_update,
    output logic [PHT_IDX_W-1:0] o_upht_wr_addr,
    output logic [1:0]           o_upht_wr_cnt,
    output logic                 o_ubtb_update,
    output logic [MXLEN-1:0]     o_ubtb_jumpsrc,
    output logic [MXLEN-1:0]     o_ubtb_jumpdst,
    input  logic                 i_upd_ready
`ifdef BPU_GHR_REPAIR_EN
    ,
    output logic                 o_ghr_repair_vld,
    output logic [GHR_W-1:0]     o_ghr_repair
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t          state;
    bpu_upd_t        push_dat;
    bpu_upd_t        head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            active;
    logic            need_upht;
    logic            need_ubtb;
    sat_cnt_t        new_cnt;
    logic            unused_ghr_msb;

    assign push     = i_br_valid && !full;
    assign o_br_ready = !full;
    assign push_dat = '{pc:      i_br_pc,
                        target:  i_br_target,
                        taken:   i_br_taken,
                        mispred: i_br_mispred,
                        ghr:     i_br_ghr,
                        cnt:     i_br_cnt};

    bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Write requests derive only from the registered head; nothing from i_br_* leaks through.
    assign active    = (state == S_ISSUE) && !empty;
    assign new_cnt   = sat_cnt_next(head.cnt, head.taken);
    assign need_upht = active && (new_cnt != head.cnt);
    assign need_ubtb = active && (head.taken || head.mispred);

    // A head with nothing to write retires without waiting for the arrays.
    assign pop = active && (i_upd_ready || !(need_upht || need_ubtb));

    assign o_upht_update  = need_upht;
    assign o_upht_wr_addr = need_upht ? (head.pc[PHT_IDX_W+2:3] ^ head.ghr[PHT_IDX_W-1:0]) : '0;
    assign o_upht_wr_cnt  = need_upht ? new_cnt : '0;
    assign o_ubtb_update  = need_ubtb;
    assign o_ubtb_jumpsrc = need_ubtb ? head.pc : '0;
    // A not-taken mispredict overwrites the entry with the fall-through, invalidating the jump.
    assign o_ubtb_jumpdst = !need_ubtb ? '0 :
                            (!head.taken && head.mispred) ? head.pc + MXLEN'(4) : head.target;

    // The top GHR bit lies outside the uPHT index range.
    assign unused_ghr_msb = head.ghr[GHR_W-1];

    // Issue FSM: enter S_ISSUE on the first push so the head drives the ports the next cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (push) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (pop && (count == CW'(1)) && !push) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BPU_GHR_REPAIR_EN
    // Mispredict repair: shift the resolved direction into the snapshot, one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_ghr_repair_vld <= 1'b0;
            o_ghr_repair     <= '0;
        end else begin
            o_ghr_repair_vld <= push && i_br_mispred;
            if (push && i_br_mispred) o_ghr_repair <= {i_br_ghr[GHR_W-2:0], i_br_taken};
        end
    end
`endif

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Randomized + directed bench for bpu_update_ctrl with a queue-level reference model.
// Stimulus drives #1 after posedge; monitor and model sample on negedge.
// Expected writes go into a scoreboard queue consumed by a separate monitor on each handshake.
`timescale 1ns/1ps
module tb_bpu_update_ctrl;
    import bpu_pkg::*;

    localparam int DEPTH = 4;

    logic                 i_clk = 1'b0;
    logic                 i_rstn;
    logic                 i_br_valid;
    logic                 o_br_ready;
    logic [31:0]          i_br_pc;
    logic [31:0]          i_br_target;
    logic                 i_br_taken;
    logic                 i_br_mispred;
    logic [9:0]           i_br_ghr;
    logic [1:0]           i_br_cnt;
    logic                 o_upht_update;
    logic [8:0]           o_upht_wr_addr;
    logic [1:0]           o_upht_wr_cnt;
    logic                 o_ubtb_update;
    logic [31:0]          o_ubtb_jumpsrc;
    logic [31:0]          o_ubtb_jumpdst;
    logic                 i_upd_ready;
`ifdef BPU_GHR_REPAIR_EN
    logic                 o_ghr_repair_vld;
    logic [9:0]           o_ghr_repair;
`endif

    bpu_update_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_br_valid     (i_br_valid),
        .o_br_ready     (o_br_ready),
        .i_br_pc        (i_br_pc),
        .i_br_target    (i_br_target),
        .i_br_taken     (i_br_taken),
        .i_br_mispred   (i_br_mispred),
        .i_br_ghr       (i_br_ghr),
        .i_br_cnt       (i_br_cnt),
        .o_upht_update  (o_upht_update),
        .o_upht_wr_addr (o_upht_wr_addr),
        .o_upht_wr_cnt  (o_upht_wr_cnt),
        .o_ubtb_update  (o_ubtb_update),
        .o_ubtb_jumpsrc (o_ubtb_jumpsrc),
        .o_ubtb_jumpdst (o_ubtb_jumpdst),
        .i_upd_ready    (i_upd_ready)
`ifdef BPU_GHR_REPAIR_EN
        ,
        .o_ghr_repair_vld (o_ghr_repair_vld),
        .o_ghr_repair     (o_ghr_repair)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        mispred;
        logic [9:0]  ghr;
        logic [1:0]  cnt;
    } rec_t;

    typedef struct {
        logic        upht;
        logic [8:0]  addr;
        logic [1:0]  cnt;
        logic        ubtb;
        logic [31:0] src;
        logic [31:0] dst;
    } exp_t;

    rec_t model_q[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: counter moves one step toward the outcome, clamped to 0..3.
    function automatic exp_t expect_of(input rec_t r);
        exp_t e;
        int   c;
        int   n;
        c = int'(r.cnt);
        if (r.taken) n = (c + 1 > 3) ? 3 : c + 1;
        else         n = (c - 1 < 0) ? 0 : c - 1;
        e.cnt  = 2'(n);
        e.upht = (n != c);
        e.addr = 9'(((r.pc / 8) % 512) ^ (32'(r.ghr) % 512));
        e.ubtb = r.taken || r.mispred;
        e.src  = r.pc;
        e.dst  = (!r.taken && r.mispred) ? r.pc + 32'd4 : r.target;
        return e;
    endfunction

    function automatic bit has_write(input rec_t r);
        exp_t e;
        e = expect_of(r);
        return e.upht || e.ubtb;
    endfunction

    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                                input logic mp, input logic [9:0] ghr, input logic [1:0] cnt);
        rec_t r;
        r.pc = pc; r.target = tgt; r.taken = tk; r.mispred = mp; r.ghr = ghr; r.cnt = cnt;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc      = $urandom;
        r.target  = $urandom;
        r.taken   = 1'($urandom_range(0, 1));
        r.mispred = ($urandom_range(0, 3) == 0);
        r.ghr     = 10'($urandom);
        r.cnt     = 2'($urandom_range(0, 3));
        return r;
    endfunction

    // One cycle: drive, then on negedge check readiness and advance the queue model.
    task automatic tick(input bit v, input rec_t r, input bit rdy, output bit acc);
        bit room;
        i_br_valid   = v;
        i_br_pc      = r.pc;
        i_br_target  = r.target;
        i_br_taken   = r.taken;
        i_br_mispred = r.mispred;
        i_br_ghr     = r.ghr;
        i_br_cnt     = r.cnt;
        i_upd_ready  = rdy;
        @(negedge i_clk);
        room = (model_q.size() < DEPTH);
        chk("br_ready", 96'(o_br_ready), 96'(room));
        if (model_q.size() > 0 && (rdy || !has_write(model_q[0]))) model_q.delete(0);
        acc = v && room;
        if (acc) begin
            model_q.push_back(r);
            if (has_write(r)) sb.push_back(expect_of(r));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        rec_t nop;
        bit   acc;
        nop = mk(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 30 && model_q.size() > 0; k++) tick(0, nop, 1, acc);
        tick(0, nop, 1, acc);
        chk("sb_empty", 96'(sb.size()), 96'(0));
    endtask

    // Monitor: every handshake consumes the oldest expected write; stalled heads must hold.
    exp_t        mon_e;
    logic [76:0] mon_cur;
    logic [76:0] mon_prev;
    bit          mon_held = 0;
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            mon_held = 0;
        end else if (o_upht_update || o_ubtb_update) begin
            mon_cur = {o_upht_update, o_upht_wr_addr, o_upht_wr_cnt,
                       o_ubtb_update, o_ubtb_jumpsrc, o_ubtb_jumpdst};
            if (mon_held) chk("hold_stable", 96'(mon_cur), 96'(mon_prev));
            if (i_upd_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_write", 96'(mon_cur), 96'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("upht_write",
                        96'({o_upht_update, mon_e.upht ? {o_upht_wr_addr, o_upht_wr_cnt} : 11'd0}),
                        96'({mon_e.upht, mon_e.upht ? {mon_e.addr, mon_e.cnt} : 11'd0}));
                    chk("ubtb_write",
                        96'({o_ubtb_update, mon_e.ubtb ? {o_ubtb_jumpsrc, o_ubtb_jumpdst} : 64'd0}),
                        96'({mon_e.ubtb, mon_e.ubtb ? {mon_e.src, mon_e.dst} : 64'd0}));
                end
                mon_held = 0;
            end else begin
                mon_held = 1;
                mon_prev = mon_cur;
            end
        end else begin
            mon_held = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t nop;
        rec_t r;
        rec_t r0;
        rec_t r1;
        rec_t cur;
        rec_t bp[5];
        bit   acc;
        bit   have;
        int   h0;

        nop = mk(0, 0, 0, 0, 0, 0);
        i_rstn = 1'b0;
        i_br_valid = 0; i_br_pc = 0; i_br_target = 0; i_br_taken = 0;
        i_br_mispred = 0; i_br_ghr = 0; i_br_cnt = 0; i_upd_ready = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_outputs", 96'({o_upht_update, o_upht_wr_addr, o_upht_wr_cnt, o_ubtb_update,
                                o_ubtb_jumpsrc, o_ubtb_jumpdst}), 96'(0));
        chk("rst_br_ready", 96'(o_br_ready), 96'(1));
`ifdef BPU_GHR_REPAIR_EN
        chk("rst_repair", 96'({o_ghr_repair_vld, o_ghr_repair}), 96'(0));
`endif
        i_rstn = 1'b1;

        // Single record: write ports active the cycle after acceptance, idle after handshake.
        r = mk(32'h1008, 32'h0000_2000, 1, 0, 10'h005, 2'd1);
        tick(1, r, 1, acc);
        #2;
        chk("t1_upht", 96'({o_upht_update, o_upht_wr_addr, o_upht_wr_cnt}), 96'({1'b1, 9'h004, 2'd2}));
        chk("t1_ubtb", 96'({o_ubtb_update, o_ubtb_jumpsrc, o_ubtb_jumpdst}),
            96'({1'b1, 32'h1008, 32'h0000_2000}));
        tick(0, nop, 1, acc);
        #2;
        chk("t1_idle", 96'({o_upht_update, o_ubtb_update}), 96'(0));

        // Saturated taken counter: only the uBTB write.
        r = mk(32'h0000_4010, 32'h0000_5000, 1, 0, 10'h3FF, 2'd3);
        tick(1, r, 1, acc);
        #2;
        chk("sat_taken", 96'({o_upht_update, o_ubtb_update}), 96'({1'b0, 1'b1}));
        tick(0, nop, 1, acc);

        // No-write head retires at once even with the arrays stalled.
        r0 = mk(32'h0000_6000, 32'h0000_7000, 0, 0, 10'h011, 2'd0);
        r1 = mk(32'h0000_8008, 32'h0000_9000, 1, 0, 10'h022, 2'd1);
        tick(1, r0, 0, acc);
        tick(1, r1, 0, acc);
        #2;
        chk("nowrite_pop", 96'({o_ubtb_update, o_ubtb_jumpsrc}), 96'({1'b1, 32'h0000_8008}));
        drain();

        // Back-pressure: four fill the queue, the fifth waits, then four issue back to back.
        for (int i = 0; i < 5; i++) bp[i] = mk(32'h100 * (i + 1), 32'hA000 + i, 1, 0, 10'(i), 2'd1);
        have = 1;
        for (int i = 0; i < 5; i++) tick(1, bp[i], 0, acc);
        have = !acc;
        for (int i = 0; i < 2; i++) tick(have, bp[4], 0, acc);
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            tick(have, bp[4], 1, acc);
            if (acc) have = 0;
        end
        chk("bp_consecutive", 96'(hs_cnt - h0), 96'(4));
        drain();

        // Simultaneous push/pop at occupancy 2, then refill to show occupancy held at 2.
        tick(1, mk(32'h2000, 32'h3000, 1, 1, 10'h1, 2'd2), 0, acc);
        tick(1, mk(32'h2100, 32'h3100, 0, 1, 10'h2, 2'd2), 0, acc);
        for (int i = 0; i < 6; i++) tick(1, mk(32'h2200 + 32'(i * 8), 32'h3200 + 32'(i), 1, 0, 10'(i), 2'd0), 1, acc);
        for (int i = 0; i < 3; i++) tick(1, mk(32'h2400 + 32'(i * 8), 32'h3400, 1, 0, 10'h0, 2'd0), 0, acc);
        drain();

        // Asynchronous reset with three entries pending.
        for (int i = 0; i < 3; i++) tick(1, mk(32'h5000 + 32'(i * 4), 32'h6000, 1, 0, 10'h3, 2'd1), 0, acc);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("rst_async_out", 96'({o_upht_update, o_ubtb_update}), 96'(0));
        model_q.delete();
        sb.delete();
        tick(0, nop, 0, acc);
        i_rstn = 1'b1;
        tick(0, nop, 1, acc);
        chk("rst_after_empty", 96'({o_br_ready, o_upht_update, o_ubtb_update}), 96'({1'b1, 2'b00}));

`ifdef BPU_GHR_REPAIR_EN
        tick(1, mk(32'h7000, 32'h7100, 1, 1, 10'h2AA, 2'd1), 1, acc);
        #2;
        chk("repair_pulse", 96'({o_ghr_repair_vld, o_ghr_repair}), 96'({1'b1, 10'h155}));
        tick(0, nop, 1, acc);
        #2;
        chk("repair_one_cycle", 96'(o_ghr_repair_vld), 96'(0));
        tick(1, mk(32'h7200, 32'h7300, 1, 0, 10'h2AA, 2'd1), 1, acc);
        #2;
        chk("repair_none", 96'(o_ghr_repair_vld), 96'(0));
        drain();
`endif

        // Random traffic with valid held until accepted.
        have = 0;
        cur = nop;
        for (int c = 0; c < 400; c++) begin
            if (!have && $urandom_range(0, 99) < 60) begin
                cur = rand_rec();
                have = 1;
            end
            tick(have, cur, $urandom_range(0, 99) < 65, acc);
            if (acc) have = 0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
